// File: rtl/mul4_seq_pkg.sv
// Shared constants for the sequential 4x4 shift-add multiplier.
//   IDLE/CALC/DONE : FSM state encodings (2-bit)
//   ITERS          : shift-add iterations per product
//   W              : operand width, fixed by the padd datapath
package mul4_seq_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned ITERS = 4;
  localparam int unsigned W     = 4;

endpackage

// File: rtl/mul4_seq_padd.sv
// 4-bit ripple-carry adder shared by the multiplier datapath.
//   a, b : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out
module padd (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-add multiplier with valid/ready on both sides.
// One padd instance is reused over four iterations; fixed 4-edge latency.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand pair presented
//   in_ready  : accepting operands (IDLE only)
//   a, b      : multiplicand, multiplier
//   out_valid : p holds a completed product (DONE only)
//   out_ready : consumer accepts the product
//   p         : registered product a*b
module mul4_seq
  import mul4_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   p
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] q_q, q_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [7:0]   p_q, p_d;

  logic [W-1:0] sum;
  logic         carry;

  padd u_padd (
    .a    (a_q),
    .b    (m_q),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Right-shift of {carry, A(+M), Q}; the adder carry lands in A[3].
        if (q_q[0]) begin
          {a_d, q_d} = {carry, sum, q_q[3:1]};
        end else begin
          {a_d, q_d} = {1'b0, a_q, q_q[3:1]};
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(ITERS - 1)) begin
          p_d     = {a_d, q_d};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_mul4_seq.sv
module tb_mul4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mul4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One transaction: accept, count latency, optional output stall, handshake.
  task automatic do_op(input logic [3:0] op_a, input logic [3:0] op_b, input int stall,
                       input bit hold);
    int n;
    logic [7:0] exp_p;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("accept_ready", {7'd0, in_ready}, 8'd1);
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back({4'd0, op_a} * {4'd0, op_b});
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    // Garbage operands while busy must not be latched.
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    n = 0;
    while (!out_valid && n < 12) begin
      check("calc_ready_low", {7'd0, in_ready}, 8'd0);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", 8'(n), 8'd4);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_p = 8'h00;
    if (exp_q.size() != 0) exp_p = exp_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", {7'd0, out_valid}, 8'd1);
      check("stall_ready", {7'd0, in_ready}, 8'd0);
      check("stall_p", p, exp_p);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("out_valid", {7'd0, out_valid}, 8'd1);
    check("product", p, exp_p);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", {7'd0, out_valid}, 8'd0);
    check("ready_back", {7'd0, in_ready}, 8'd1);
    check("p_retained", p, exp_p);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {7'd0, in_ready}, 8'd1);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_p", p, 8'h00);

    do_op(4'd13, 4'd11, 0, 1'b0);
    do_op(4'd15, 4'd15, 0, 1'b0);
    do_op(4'd0, 4'd9, 0, 1'b1);
    do_op(4'd9, 4'd0, 0, 1'b0);
    do_op(4'd7, 4'd6, 3, 1'b0);

    // Reset mid-calculation: accept at E0, reset sampled at E2.
    a        = 4'd5;
    b        = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_p", p, 8'h00);
    check("midrst_in_ready", {7'd0, in_ready}, 8'd1);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_valid", {7'd0, out_valid}, 8'd0);
      @(posedge clk);
      @(negedge clk);
    end
    do_op(4'd3, 4'd4, 0, 1'b0);

    for (int i = 0; i < 256; i++) begin
      do_op(4'(i >> 4), 4'(i), $urandom_range(0, 2), 1'b0);
    end

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
